// File: rtl/prbs13_checker.sv
// Receive-side PRBS-13 (x^13 + x^4 + x^3 + x + 1) checker: self-synchronising lock, BER counters, loss-of-lock re-hunt.
// Optional lane polarity inversion is enabled by defining PRBS13_INVERT_EN (adds the invert input).
module prbs13_checker #(
    parameter int LOCK_CNT    = 26,
    parameter int CNT_W       = 32,
    parameter int WIN_LEN     = 128,
    parameter int UNLOCK_ERRS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             din,
    input  logic             din_valid,
`ifdef PRBS13_INVERT_EN
    input  logic             invert,
`endif
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sat
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int WB_W  = $clog2(WIN_LEN + 1);
    localparam int WE_W  = $clog2(UNLOCK_ERRS + 1);
    localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
    localparam logic [WB_W-1:0]  WIN_LAST    = WB_W'(WIN_LEN - 1);
    localparam logic [WE_W-1:0]  UNLOCK_LAST = WE_W'(UNLOCK_ERRS - 1);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic logic prbs13_pred(input logic [12:0] hist);
        return hist[12] ^ hist[3] ^ hist[2] ^ hist[0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (&val) ? val : val + CNT_W'(1'b1);
    endfunction

    state_t           state_r, state_s;
    logic [12:0]      shreg_r, shreg_s;
    logic [RUN_W-1:0] run_r, run_s;
    logic [WB_W-1:0]  win_bits_r, win_bits_s;
    logic [WE_W-1:0]  win_errs_r, win_errs_s;
    logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
    logic [CNT_W-1:0] err_cnt_r, err_cnt_s;
    logic             err_sat_r, err_sat_s;
    logic             err_pulse_r, err_pulse_s;
    logic             locked_r;
    logic             din_s, pred_s, err_s;

`ifdef PRBS13_INVERT_EN
    assign din_s = din ^ invert;
`else
    assign din_s = din;
`endif
    assign pred_s = prbs13_pred(shreg_r);
    assign err_s  = din_s ^ pred_s;

    // Next-state, counter and window logic; everything holds on invalid cycles.
    always_comb begin
        state_s     = state_r;
        shreg_s     = shreg_r;
        run_s       = run_r;
        win_bits_s  = win_bits_r;
        win_errs_s  = win_errs_r;
        bit_cnt_s   = bit_cnt_r;
        err_cnt_s   = err_cnt_r;
        err_pulse_s = 1'b0;
        if (din_valid) begin
            case (state_r)
                ST_SEARCH: begin
                    shreg_s = {shreg_r[11:0], din_s};
                    // An all-zero history predicts zeros forever, so it never earns lock credit.
                    if (!err_s && (shreg_r != 13'd0)) begin
                        if (run_r == LOCK_LAST) begin
                            state_s    = ST_LOCKED;
                            run_s      = {RUN_W{1'b0}};
                            win_bits_s = {WB_W{1'b0}};
                            win_errs_s = {WE_W{1'b0}};
                        end else begin
                            run_s = run_r + RUN_W'(1'b1);
                        end
                    end else begin
                        run_s = {RUN_W{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    // Free-running reference: a single line error is counted once.
                    shreg_s   = {shreg_r[11:0], pred_s};
                    bit_cnt_s = sat_inc(bit_cnt_r);
                    if (err_s) begin
                        err_cnt_s   = sat_inc(err_cnt_r);
                        err_pulse_s = 1'b1;
                    end else begin
                        err_cnt_s   = err_cnt_r;
                    end
                    if (err_s && (win_errs_r == UNLOCK_LAST)) begin
                        state_s    = ST_SEARCH;
                        run_s      = {RUN_W{1'b0}};
                        win_bits_s = {WB_W{1'b0}};
                        win_errs_s = {WE_W{1'b0}};
                    end else if (win_bits_r == WIN_LAST) begin
                        win_bits_s = {WB_W{1'b0}};
                        win_errs_s = {WE_W{1'b0}};
                    end else begin
                        win_bits_s = win_bits_r + WB_W'(1'b1);
                        win_errs_s = err_s ? win_errs_r + WE_W'(1'b1) : win_errs_r;
                    end
                end
                default: begin
                    state_s = ST_SEARCH;
                    run_s   = {RUN_W{1'b0}};
                end
            endcase
        end else begin
            err_pulse_s = 1'b0;
        end
        err_sat_s = err_sat_r | (&bit_cnt_s) | (&err_cnt_s);
        // Clear beats a coincident valid bit: that bit is neither counted nor pulsed.
        if (clear) begin
            bit_cnt_s   = {CNT_W{1'b0}};
            err_cnt_s   = {CNT_W{1'b0}};
            err_sat_s   = 1'b0;
            err_pulse_s = 1'b0;
        end else begin
            err_sat_s   = err_sat_s;
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_SEARCH;
            shreg_r     <= 13'd0;
            run_r       <= {RUN_W{1'b0}};
            win_bits_r  <= {WB_W{1'b0}};
            win_errs_r  <= {WE_W{1'b0}};
            bit_cnt_r   <= {CNT_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
            err_sat_r   <= 1'b0;
            err_pulse_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            shreg_r     <= shreg_s;
            run_r       <= run_s;
            win_bits_r  <= win_bits_s;
            win_errs_r  <= win_errs_s;
            bit_cnt_r   <= bit_cnt_s;
            err_cnt_r   <= err_cnt_s;
            err_sat_r   <= err_sat_s;
            err_pulse_r <= err_pulse_s;
            locked_r    <= (state_s == ST_LOCKED);
        end
    end

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign bit_cnt   = bit_cnt_r;
    assign err_cnt   = err_cnt_r;
    assign err_sat   = err_sat_r;

endmodule

// File: tb/tb_prbs13_checker.sv
// Scoreboard bench for prbs13_checker: directed PRBS streams, expected snapshots and err_pulse values queued by the driver.
// A 32-bit-counter instance covers the main behaviour; a 4-bit-counter instance covers saturation.
module tb_prbs13_checker;

    logic        clock = 1'b0;
    logic        reset, clear, din, din_valid;
    logic        clear2, din2, din_valid2;
    logic        locked, err_pulse, err_sat;
    logic [31:0] bit_cnt, err_cnt;
    logic        locked2, err_pulse2, err_sat2;
    logic [3:0]  bit_cnt2, err_cnt2;
`ifdef PRBS13_INVERT_EN
    logic        invert;
    logic        invert2;
`endif

    typedef struct {
        bit          which;
        logic        lk;
        bit          chk;
        logic [31:0] bc;
        logic [31:0] ec;
        logic        sat;
    } snap_t;

    snap_t       sq[$];
    logic [31:0] pq[$];
    snap_t       cur;
    logic        snap_req;
    logic [12:0] g;
    logic [31:0] exp_err;
    logic [31:0] act_bc, act_ec, exp_pulse;
    logic        act_lk, act_sat;
    int          checks = 0;
    int          errors = 0;
    int          snap_id = 0;
    int          sat_pulses = 0;

    prbs13_checker #(.CNT_W(32)) dut (
        .clock(clock), .reset(reset), .clear(clear), .din(din), .din_valid(din_valid),
`ifdef PRBS13_INVERT_EN
        .invert(invert),
`endif
        .locked(locked), .err_pulse(err_pulse), .bit_cnt(bit_cnt), .err_cnt(err_cnt), .err_sat(err_sat)
    );

    prbs13_checker #(.CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .clear(clear2), .din(din2), .din_valid(din_valid2),
`ifdef PRBS13_INVERT_EN
        .invert(invert2),
`endif
        .locked(locked2), .err_pulse(err_pulse2), .bit_cnt(bit_cnt2), .err_cnt(err_cnt2), .err_sat(err_sat2)
    );

    always #5 clock = ~clock;

    // Monitor: pops expected err_cnt on every pulse and expected snapshots on request.
    always @(negedge clock) begin
        if (err_pulse2) sat_pulses++;
        if (err_pulse) begin
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("FAIL pulse: unexpected err_pulse, err_cnt got %0d", err_cnt);
            end else begin
                exp_pulse = pq.pop_front();
                if (err_cnt !== exp_pulse) begin
                    errors++;
                    $display("FAIL pulse.err_cnt got %0d exp %0d", err_cnt, exp_pulse);
                end
            end
        end
        if (snap_req) begin
            snap_id++;
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL snap%0d: no expected snapshot queued", snap_id);
            end else begin
                cur     = sq.pop_front();
                act_lk  = cur.which ? locked2 : locked;
                act_bc  = cur.which ? {28'd0, bit_cnt2} : bit_cnt;
                act_ec  = cur.which ? {28'd0, err_cnt2} : err_cnt;
                act_sat = cur.which ? err_sat2 : err_sat;
                if (act_lk !== cur.lk) begin
                    errors++;
                    $display("FAIL snap%0d.locked got %0b exp %0b", snap_id, act_lk, cur.lk);
                end
                if (cur.chk) begin
                    checks += 3;
                    if (act_bc !== cur.bc) begin
                        errors++;
                        $display("FAIL snap%0d.bit_cnt got %0d exp %0d", snap_id, act_bc, cur.bc);
                    end
                    if (act_ec !== cur.ec) begin
                        errors++;
                        $display("FAIL snap%0d.err_cnt got %0d exp %0d", snap_id, act_ec, cur.ec);
                    end
                    if (act_sat !== cur.sat) begin
                        errors++;
                        $display("FAIL snap%0d.err_sat got %0b exp %0b", snap_id, act_sat, cur.sat);
                    end
                end
            end
        end
    end

    task automatic drive(input bit which, input logic b, input logic v, input logic clr);
        @(posedge clock);
        #1;
        snap_req   = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        clear      = 1'b0;
        din2       = 1'b0;
        din_valid2 = 1'b0;
        clear2     = 1'b0;
        if (which) begin
            din2 = b; din_valid2 = v; clear2 = clr;
        end else begin
            din = b; din_valid = v; clear = clr;
        end
    endtask

    task automatic snap(input bit which, input logic lk, input bit chk,
                        input logic [31:0] bc, input logic [31:0] ec, input logic sat);
        snap_t s;
        @(posedge clock);
        #1;
        din_valid  = 1'b0;
        din_valid2 = 1'b0;
        clear      = 1'b0;
        clear2     = 1'b0;
        s.which = which; s.lk = lk; s.chk = chk; s.bc = bc; s.ec = ec; s.sat = sat;
        sq.push_back(s);
        snap_req = 1'b1;
    endtask

    // Generator stream; bits selected by period/phase (or all, with inv_all) are flipped.
    task automatic send_prbs(input bit which, input int n, input int period, input int phase,
                             input bit inv_all, input int budget, input bit gaps);
        logic nb;
        bit   bad;
        int   pushed;
        pushed = 0;
        for (int i = 0; i < n; i++) begin
            nb  = g[12] ^ g[3] ^ g[2] ^ g[0];
            g   = {g[11:0], nb};
            bad = inv_all || (period > 0 && (i % period) == phase);
            drive(which, nb ^ bad, 1'b1, 1'b0);
            if (bad && pushed < budget) begin
                exp_err = exp_err + 32'd1;
                pq.push_back(exp_err);
                pushed++;
            end
            if (gaps) drive(which, ~nb, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        snap_req = 1'b0;
        din = 1'b0; din_valid = 1'b0; clear = 1'b0;
        din2 = 1'b0; din_valid2 = 1'b0; clear2 = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        g       = 13'h000F;
        exp_err = 32'd0;
    endtask

    initial begin
        logic nb;
        reset = 1'b1; snap_req = 1'b0; exp_err = 32'd0; g = 13'h000F;
        din = 1'b0; din_valid = 1'b0; clear = 1'b0;
        din2 = 1'b0; din_valid2 = 1'b0; clear2 = 1'b0;
`ifdef PRBS13_INVERT_EN
        invert = 1'b0; invert2 = 1'b0;
`endif
        repeat (3) @(posedge clock);
        do_reset();
        snap(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
        snap(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);

        // All-zero input never locks.
        for (int i = 0; i < 1000; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
        snap(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);

        // Clean lock from seed 000F: bits 13..38 are the 26 good predictions.
        do_reset();
        send_prbs(1'b0, 38, 0, 0, 1'b0, 0, 1'b0);
        snap(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
        send_prbs(1'b0, 1, 0, 0, 1'b0, 0, 1'b0);
        snap(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        send_prbs(1'b0, 10000, 0, 0, 1'b0, 0, 1'b0);
        snap(1'b0, 1'b1, 1'b1, 32'd10000, 32'd0, 1'b0);

        // One flipped bit per 1000.
        send_prbs(1'b0, 10000, 1000, 499, 1'b0, 10, 1'b0);
        snap(1'b0, 1'b1, 1'b1, 32'd20000, 32'd10, 1'b0);

        // Inverted stream: 16 errors into a window at offset 32 drop lock; counters retained.
        send_prbs(1'b0, 128, 0, 0, 1'b1, 16, 1'b0);
        snap(1'b0, 1'b0, 1'b1, 32'd20016, 32'd26, 1'b0);
        send_prbs(1'b0, 39, 0, 0, 1'b0, 0, 1'b0);
        snap(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);

        // Clear together with an errored valid bit.
        nb = g[12] ^ g[3] ^ g[2] ^ g[0];
        g  = {g[11:0], nb};
        drive(1'b0, ~nb, 1'b1, 1'b1);
        exp_err = 32'd0;
        snap(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
        send_prbs(1'b0, 5, 0, 0, 1'b0, 0, 1'b0);
        snap(1'b0, 1'b1, 1'b1, 32'd5, 32'd0, 1'b0);

        // 50% din_valid duty: lock timing counts valid bits only.
        do_reset();
        send_prbs(1'b0, 38, 0, 0, 1'b0, 0, 1'b1);
        snap(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
        send_prbs(1'b0, 1, 0, 0, 1'b0, 0, 1'b1);
        snap(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
        send_prbs(1'b0, 20, 20, 9, 1'b0, 1, 1'b1);
        snap(1'b0, 1'b1, 1'b1, 32'd20, 32'd1, 1'b0);

        // Saturation on the 4-bit instance: 16th error unlocks, counters pinned at 15.
        do_reset();
        send_prbs(1'b1, 39, 0, 0, 1'b0, 0, 1'b0);
        snap(1'b1, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
        send_prbs(1'b1, 20, 0, 0, 1'b1, 0, 1'b0);
        snap(1'b1, 1'b0, 1'b1, 32'd15, 32'd15, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        snap(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);

`ifdef PRBS13_INVERT_EN
        do_reset();
        invert = 1'b1;
        send_prbs(1'b0, 39, 0, 0, 1'b1, 0, 1'b0);
        snap(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
        send_prbs(1'b0, 100, 0, 0, 1'b1, 0, 1'b0);
        snap(1'b0, 1'b1, 1'b1, 32'd100, 32'd0, 1'b0);
        invert = 1'b0;
`endif

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        checks++;
        if (sat_pulses != 16) begin
            errors++;
            $display("FAIL sat_pulses got %0d exp 16", sat_pulses);
        end
        checks++;
        if (pq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL drain: pulses left %0d snapshots left %0d exp 0", pq.size(), sq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
